// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle of the immediate-generation unit.
// The master drives requests and takes results; the slave (the unit) does the reverse.
interface imm_ext_pipe_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) ();
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        ExtSel;
   logic [IMM_W-1:0]  immediateIn;
   logic [DATA_W-1:0] pcIn;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] immediateOut;
   logic              sel_err;

   modport master (
      output flush, in_valid, ExtSel, immediateIn, pcIn, out_ready,
      input  in_ready, out_valid, immediateOut, sel_err
   );

   modport slave (
      input  flush, in_valid, ExtSel, immediateIn, pcIn, out_ready,
      output in_ready, out_valid, immediateOut, sel_err
   );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator: S1 captures the request, S2 computes and
// holds the result. Valid/ready on both sides, two requests in flight at most.
// Parameter legality: DATA_W >= IMM_W+2 and SHAMT_LO+SHAMT_W <= IMM_W.
module imm_ext_pipe #(
   parameter int DATA_W   = 32,
   parameter int IMM_W    = 16,
   parameter int SHAMT_LO = 6,
   parameter int SHAMT_W  = 5
) (
   input logic          CLK,
   input logic          RST,
   imm_ext_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      EXT_SHAMT  = 3'b000,
      EXT_ZERO   = 3'b001,
      EXT_SIGN   = 3'b010,
      EXT_UPPER  = 3'b011,
      EXT_SHIFT2 = 3'b100,
      EXT_BRANCH = 3'b101
   } ext_mode_e;

   // Stage 1: captured request
   logic              s1_valid;
   logic [2:0]        s1_sel;
   logic [IMM_W-1:0]  s1_imm;
   logic [DATA_W-1:0] s1_pc;

   // Stage 2: presented result
   logic              s2_valid;
   logic [DATA_W-1:0] s2_data;
   logic              s2_err;

   logic              s2_adv;
   logic              s1_load;
   logic [DATA_W-1:0] sx;
   logic [DATA_W-1:0] result;
   logic              result_err;

   // S2 moves when it is empty or its result is being taken; S1 can refill
   // in the same cycle, so in_ready depends on out_ready but never on in_valid.
   assign s2_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_adv;
   assign s1_load      = bus.in_ready && bus.in_valid;

   assign bus.out_valid    = s2_valid;
   assign bus.immediateOut = s2_data;
   assign bus.sel_err      = s2_err;

   assign sx = {{(DATA_W-IMM_W){s1_imm[IMM_W-1]}}, s1_imm};

   // Result of the request sitting in S1; undefined codes give 0 plus an error flag.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      result     = '0;
      result_err = 1'b0;
      case (s1_sel)
         EXT_SHAMT:  result = {{(DATA_W-SHAMT_W){1'b0}}, s1_imm[SHAMT_LO +: SHAMT_W]};
         EXT_ZERO:   result = {{(DATA_W-IMM_W){1'b0}}, s1_imm};
         EXT_SIGN:   result = sx;
         EXT_UPPER:  result = {s1_imm, {(DATA_W-IMM_W){1'b0}}};
         EXT_SHIFT2: result = sx << 2;
         EXT_BRANCH: result = s1_pc + (sx << 2);
         default:    result_err = 1'b1;
      endcase
   end

   // Pipeline valid bits and result register; reset beats flush, flush beats traffic.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!RST) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_err   <= 1'b0;
      end else if (bus.flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            // The result only changes on a real load, so it stays put after consumption.
            if (s1_valid) begin
               s2_data <= result;
               s2_err  <= result_err;
            end
         end
         if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
         end
      end
   end

   // S1 request capture; qualified by s1_valid, so these need no reset.
   always_ff @(posedge CLK) begin
      // NOTE: plain data registers are left unreset; only the valid bits gate their use.
      if (s1_load && !bus.flush) begin
         s1_sel <= bus.ExtSel;
         s1_imm <= bus.immediateIn;
         s1_pc  <= bus.pcIn;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_ext_pipe;
   localparam int DATA_W = 32;
   localparam int IMM_W  = 16;

   logic CLK;
   logic RST;
   int   total;
   int   bad;
   logic [DATA_W:0] sb[$];   // {sel_err, immediateOut}
   logic stall_prev;
   logic [DATA_W-1:0] prev_data;
   logic prev_err;
   logic rand_rdy;

   imm_ext_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

   imm_ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_LO(6), .SHAMT_W(5)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Present one request, wait (bounded) for acceptance, record its expected result.
   task automatic send(input logic [2:0] sel, input logic [15:0] imm, input logic [31:0] pc,
                       input logic [31:0] exp_d, input logic exp_e);
      logic accepted;
      accepted        = 1'b0;
      bus.in_valid    = 1'b1;
      bus.ExtSel      = sel;
      bus.immediateIn = imm;
      bus.pcIn        = pc;
      for (int i = 0; i < 64; i++) begin
         @(negedge CLK);
         if (bus.in_ready) begin
            sb.push_back({exp_e, exp_d});
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready stayed 0 for sel %b", sel);
      end else begin
         @(posedge CLK);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // Independent reference: signed arithmetic instead of bit splicing.
   function automatic logic [DATA_W:0] model(input logic [2:0] sel, input logic [15:0] imm,
                                             input logic [31:0] pc);
      logic signed [31:0] s;
      logic [31:0] u;
      s = 32'($signed(imm));
      u = {16'h0, imm};
      case (sel)
         3'd0: return {1'b0, 32'((u / 64) % 32)};
         3'd1: return {1'b0, u};
         3'd2: return {1'b0, s};
         3'd3: return {1'b0, 32'(u * 65536)};
         3'd4: return {1'b0, 32'(s * 4)};
         3'd5: return {1'b0, 32'(pc + 32'(s * 4))};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Monitor: compare each transfer out, and check stalled outputs hold steady.
   always @(negedge CLK) begin
      if (RST && !bus.flush) begin
         if (stall_prev && bus.out_valid) begin
            check("hold_data", 64'(bus.immediateOut), 64'(prev_data));
            check("hold_err", 64'(bus.sel_err), 64'(prev_err));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got %h with empty scoreboard", bus.immediateOut);
            end else begin
               logic [DATA_W:0] e;
               e = sb.pop_front();
               check("out_data", 64'(bus.immediateOut), 64'(e[DATA_W-1:0]));
               check("out_err", 64'(bus.sel_err), 64'(e[DATA_W]));
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_data  = bus.immediateOut;
         prev_err   = bus.sel_err;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Random back-pressure source for the streaming phase.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      total = 0;
      bad = 0;
      stall_prev = 1'b0;
      rand_rdy = 1'b0;
      RST = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.ExtSel = 3'b000;
      bus.immediateIn = '0;
      bus.pcIn = '0;
      bus.out_ready = 1'b1;

      // Reset state
      idle(3);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data", 64'(bus.immediateOut), 64'd0);
      check("rst_err", 64'(bus.sel_err), 64'd0);
      RST = 1'b1;
      idle(1);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Mode sweep with latency check: accept at N, valid after N+1
      send(3'b000, 16'h8F43, 32'h0000_1000, 32'h0000_001D, 1'b0);
      check("lat0_n", 64'(bus.out_valid), 64'd0);
      idle(1);
      check("lat0_n1", 64'(bus.out_valid), 64'd1);
      idle(1);
      send(3'b001, 16'h8F43, 32'h0000_1000, 32'h0000_8F43, 1'b0);
      idle(1);
      check("lat1_n1", 64'(bus.out_valid), 64'd1);
      idle(1);
      send(3'b010, 16'h8F43, 32'h0000_1000, 32'hFFFF_8F43, 1'b0);
      idle(2);
      send(3'b011, 16'h8F43, 32'h0000_1000, 32'h8F43_0000, 1'b0);
      idle(2);
      send(3'b100, 16'h8F43, 32'h0000_1000, 32'hFFFE_3D0C, 1'b0);
      idle(2);
      send(3'b101, 16'h8F43, 32'h0000_1000, 32'hFFFE_4D0C, 1'b0);
      idle(3);
      check("hold_after_consume", 64'(bus.immediateOut), 64'h0000_0000_FFFE_4D0C);
      check("sweep_drained", 64'(sb.size()), 64'd0);

      // Branch wrap-around
      send(3'b101, 16'h0002, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0);
      idle(2);

      // Undefined mode flows through, next defined request clears the flag
      send(3'b110, 16'h8F43, 32'h0000_1000, 32'h0000_0000, 1'b1);
      idle(1);
      check("undef_valid", 64'(bus.out_valid), 64'd1);
      check("undef_err", 64'(bus.sel_err), 64'd1);
      send(3'b111, 16'h0001, 32'h0, 32'h0, 1'b1);
      send(3'b001, 16'h0042, 32'h0, 32'h0000_0042, 1'b0);
      idle(1);
      check("err_cleared", 64'(bus.sel_err), 64'd0);
      idle(2);

      // Back-pressure: two fill the pipe, the third waits
      bus.out_ready = 1'b0;
      send(3'b001, 16'h1234, 32'h0, 32'h0000_1234, 1'b0);
      send(3'b010, 16'h8000, 32'h0, 32'hFFFF_8000, 1'b0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_first", 64'(bus.immediateOut), 64'h0000_0000_0000_1234);
      bus.in_valid = 1'b1;
      bus.ExtSel = 3'b011;
      bus.immediateIn = 16'h00AB;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("bp_blocked", 64'(bus.in_ready), 64'd0);
      end
      sb.push_back({1'b0, 32'h00AB_0000});
      @(posedge CLK);
      #1;
      bus.out_ready = 1'b1;
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      check("drain_1", 64'(bus.out_valid), 64'd1);
      idle(1);
      check("drain_2", 64'(bus.out_valid), 64'd1);
      check("drain_2_data", 64'(bus.immediateOut), 64'h0000_0000_00AB_0000);
      idle(1);
      check("drain_done", 64'(bus.out_valid), 64'd0);
      check("drain_empty", 64'(sb.size()), 64'd0);

      // Flush with two in flight; the concurrent input is dropped
      bus.out_ready = 1'b0;
      send(3'b001, 16'h1111, 32'h0, 32'h0000_1111, 1'b0);
      send(3'b001, 16'h2222, 32'h0, 32'h0000_2222, 1'b0);
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.ExtSel = 3'b001;
      bus.immediateIn = 16'h5555;
      @(posedge CLK);
      #1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      idle(3);
      check("flush_dropped", 64'(bus.out_valid), 64'd0);

      // Reset with two in flight
      bus.out_ready = 1'b0;
      send(3'b010, 16'hF00F, 32'h0, 32'hFFFF_F00F, 1'b0);
      send(3'b100, 16'h0003, 32'h0, 32'h0000_000C, 1'b0);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      sb.delete();
      check("mrst_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_data", 64'(bus.immediateOut), 64'd0);
      check("mrst_err", 64'(bus.sel_err), 64'd0);
      check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      idle(3);
      check("mrst_no_partial", 64'(bus.out_valid), 64'd0);

      // Streaming with random back-pressure and gaps
      rand_rdy = 1'b1;
      for (int n = 0; n < 100; n++) begin
         logic [2:0]  sel;
         logic [15:0] imm;
         logic [31:0] pc;
         logic [DATA_W:0] e;
         sel = 3'($urandom_range(0, 7));
         imm = 16'($urandom);
         pc  = $urandom;
         e   = model(sel, imm, pc);
         send(sel, imm, pc, e[DATA_W-1:0], e[DATA_W]);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_rdy = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
      check("stream_drain", 64'(sb.size()), 64'd0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-generation unit for the multicycle CPU datapath. It replaces the combinational extender and adds two modes: upper-immediate placement and branch-target arithmetic. It also adds a two-stage valid/ready pipeline, so the instruction-decode state can hand off an immediate and the execute state consumes it with back-pressure. An undefined mode code raises an error flag instead of silently holding a stale value.

## Interface
- `DATA_W`, default 32: output width; must be ≥ IMM_W+2.
- `IMM_W`, default 16: immediate field width.
- `SHAMT_LO`, default 6: LSB position of the shift-amount field inside `immediateIn`.
- `SHAMT_W`, default 5: shift-amount width; SHAMT_LO+SHAMT_W ≤ IMM_W.
- `CLK`, in, 1: rising-edge clock; the only clock.
- `RST`, in, 1: reset, synchronous, active-low; sampled on the rising edge of `CLK`.
- `flush`, in, 1: synchronous pipeline flush; when high, both stages are cleared.
- `in_valid`, in, 1: the request on `ExtSel`/`immediateIn`/`pcIn` is valid.
- `in_ready`, out, 1: the unit can accept a request this cycle.
- `ExtSel`, in, 3: mode select.
- `immediateIn`, in, IMM_W: raw immediate field.
- `pcIn`, in, DATA_W: PC+4 of the instruction; used by mode 101 only.
- `out_valid`, out, 1: `immediateOut` holds a result.
- `out_ready`, in, 1: the consumer takes the result this cycle.
- `immediateOut`, out, DATA_W: result.
- `sel_err`, out, 1: the current result came from an undefined `ExtSel`.

## Operation
- A transfer into the unit occurs when `in_valid && in_ready` at a rising edge.
- A transfer out of the unit occurs when `out_valid && out_ready` at a rising edge.
- Stage 1 (S1) registers `ExtSel`, `immediateIn` and `pcIn`.
- Stage 2 (S2) computes the result from S1 and registers it into `immediateOut`/`sel_err`.
- Modes (`sx` = `immediateIn` sign-extended to DATA_W):
  - 000: zero-extend of `immediateIn[SHAMT_LO+SHAMT_W-1:SHAMT_LO]`.
  - 001: zero-extend of `immediateIn`.
  - 010: `sx`.
  - 011: `immediateIn` placed in the upper bits, i.e. `immediateIn << (DATA_W-IMM_W)`; low bits are 0.
  - 100: `sx << 2`, truncated to DATA_W.
  - 101: `pcIn + (sx << 2)`, modulo 2^DATA_W; carry-out is discarded and wrap-around is legal.
  - 110, 111: result is 0 and `sel_err` = 1. These are not dropped; they flow through the pipeline like any other request.
- `sel_err` = 0 for all defined modes.
- Back-pressure:
  - S2 advances when `!out_valid || out_ready`.
  - S1 advances when S1 is empty or S2 advances.
  - `in_ready` = S1 empty or S2 advances. This is combinational from `out_ready`; there is no combinational path from `in_valid`.
- Hold: while `out_valid && !out_ready`, `immediateOut` and `sel_err` stay constant. Both also stay constant after a result has been consumed, until the next S2 load.
- Simultaneous S2 consume and S1 advance in the same cycle: the new result loads and `out_valid` stays 1, giving one result per cycle.
- Flush:
  - Clears both valid bits; data registers are untouched.
  - `in_ready` = 1 in the cycle after a flush.
  - An input presented in the same cycle as `flush` is discarded.
  - Flush has lower priority than reset.

## Timing
- Reset values: `out_valid` = 0, S1 valid = 0, `immediateOut` = 0, `sel_err` = 0. `in_ready` = 1 from the first edge after reset is released.
- Reset asserted mid-operation: all in-flight requests are discarded at that edge. No partial result appears.
- Latency is 2 cycles:
  - Request accepted at edge N.
  - `out_valid` = 1 with the result after edge N+1, provided S2 was free.
- Throughput: 1 request/cycle when `out_ready` = 1 continuously.
- Capacity: at most 2 requests in flight. With `out_ready` = 0, the third request sees `in_ready` = 0.
- Inputs only need to be stable around the accepting edge. They may change freely at any other time.

## Test plan
- Mode sweep, defaults, `out_ready` = 1, `immediateIn` = 16'h8F43, `pcIn` = 32'h0000_1000:
  - 000 -> 32'h0000_001D
  - 001 -> 32'h0000_8F43
  - 010 -> 32'hFFFF_8F43
  - 011 -> 32'h8F43_0000
  - 100 -> 32'hFFFE_3D0C
  - 101 -> 32'hFFFE_4D0C
  - Each result appears exactly 2 cycles after acceptance.
- Branch wrap-around: mode 101, `pcIn` = 32'hFFFF_FFFC, `immediateIn` = 16'h0002 -> 32'h0000_0004, `sel_err` = 0.
- Undefined mode: `ExtSel` = 3'b110 -> `immediateOut` = 0, `sel_err` = 1, `out_valid` = 1. The next request in mode 001 clears `sel_err`.
- Back-pressure:
  - Hold `out_ready` = 0 and send 3 back-to-back requests.
  - `in_ready` drops after the 2nd request is accepted; the 1st result holds steady.
  - Release `out_ready`: results drain in order, one per cycle, none lost or duplicated.
- Flush/reset mid-flight:
  - With 2 requests in flight, pulse `flush` -> `out_valid` = 0 the next cycle, `in_ready` = 1.
  - Repeat with `RST` = 0 for 1 cycle -> all outputs return to their reset values.
- Streaming: 100 random requests with random `out_ready`, checked against a reference model. The output sequence must match the input order exactly.
